// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decoder-facing instruction fields and
// the stall/branch feedback coming back from downstream.
interface instruction_fetch_unit_if #(
    parameter int PC_WIDTH = 8
);
    logic                stall;
    logic                branch_taken;
    logic [8:0]          branch_offset;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_rdata;
    logic                instr_valid;
    logic [PC_WIDTH-1:0] instr_pc;
    logic [15:0]         instr;
    logic [3:0]          opcode;
    logic [6:0]          immediate;
    logic [5:0]          nzimm;
    logic [8:0]          offset;
    logic                halted;
    logic [15:0]         instr_count;
    logic [1:0]          dbg_state;

    // Handshake: instr_valid marks IR as meaningful; the instruction is consumed on a
    // rising edge where instr_valid=1 and stall=0 (or branch_taken=1, which overrides
    // stall). While stall=1 every instruction output holds its value.
    modport master (
        input  stall, branch_taken, branch_offset, imem_rdata,
        output imem_addr, instr_valid, instr_pc, instr, opcode, immediate, nzimm,
               offset, halted, instr_count, dbg_state
    );

    modport slave (
        output stall, branch_taken, branch_offset, imem_rdata,
        input  imem_addr, instr_valid, instr_pc, instr, opcode, immediate, nzimm,
               offset, halted, instr_count, dbg_state
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives a synchronous-read instruction memory and holds
// the instruction register presented to the decoder, with stall, redirect and halt.
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]          HALT_OPCODE = 4'b1111
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e              state_q;
    logic [PC_WIDTH-1:0] fetch_pc_q;
    logic [PC_WIDTH-1:0] req_pc_q;
    logic                req_valid_q;
    logic [15:0]         ir_q;
    logic [PC_WIDTH-1:0] instr_pc_q;
    logic                instr_valid_q;
    logic [15:0]         count_q;

    logic [PC_WIDTH-1:0] off_ext;
    logic [PC_WIDTH-1:0] target;
    logic                halt_go;
    logic                redirect;
    logic                advance;

    assign off_ext = PC_WIDTH'($signed(bus.branch_offset));
    assign target  = instr_pc_q + PC_WIDTH'(1) + off_ext;

    // A halt in IR wins over a branch on the same instruction: nothing past it is fetched.
    assign halt_go  = (state_q == S_RUN) && instr_valid_q && (ir_q[15:12] == HALT_OPCODE)
                      && !bus.stall;
    assign redirect = (state_q == S_RUN) && instr_valid_q && bus.branch_taken && !halt_go;
    assign advance  = (state_q == S_RUN) && !redirect && !halt_go && !bus.stall;

    always_comb begin
        bus.imem_addr = fetch_pc_q;
        if (reset) begin
            bus.imem_addr = RESET_PC;
        end else if (redirect) begin
            bus.imem_addr = target;
        end else if ((state_q == S_RUN) && bus.stall && req_valid_q) begin
            // Re-request so the data arriving next cycle is still the pending word.
            bus.imem_addr = req_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FILL;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            req_valid_q   <= 1'b0;
            ir_q          <= 16'h0000;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            count_q       <= 16'h0000;
        end else begin
            case (state_q)
                S_FILL: begin
                    fetch_pc_q  <= RESET_PC + PC_WIDTH'(1);
                    req_pc_q    <= RESET_PC;
                    req_valid_q <= 1'b1;
                    state_q     <= S_RUN;
                end
                S_RUN: begin
                    if (halt_go) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_HALT;
                    end else if (redirect) begin
                        req_pc_q      <= target;
                        req_valid_q   <= 1'b1;
                        fetch_pc_q    <= target + PC_WIDTH'(1);
                        instr_valid_q <= 1'b0;
                    end else if (advance) begin
                        ir_q          <= bus.imem_rdata;
                        instr_pc_q    <= req_pc_q;
                        instr_valid_q <= req_valid_q;
                        req_pc_q      <= fetch_pc_q;
                        fetch_pc_q    <= fetch_pc_q + PC_WIDTH'(1);
                        if (req_valid_q && (count_q != 16'hFFFF)) begin
                            count_q <= count_q + 16'd1;
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FILL;
                end
            endcase
        end
    end

    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr       = ir_q;
    assign bus.opcode      = ir_q[15:12];
    assign bus.immediate   = ir_q[6:0];
    assign bus.nzimm       = ir_q[5:0];
    assign bus.offset      = ir_q[8:0];
    assign bus.halted      = (state_q == S_HALT);
    assign bus.instr_count = count_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: an instruction-flow model predicts which
// (pc, word) pairs the decoder should consume; a negedge monitor checks them.
module tb_instruction_fetch_unit;
    logic clk;
    logic reset;

    instruction_fetch_unit_if #(.PC_WIDTH(8)) bus ();

    instruction_fetch_unit #(
        .PC_WIDTH   (8),
        .RESET_PC   (8'd0),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- synchronous instruction memory ----------------
    logic [15:0] imem [256];
    always @(posedge clk) bus.imem_rdata <= imem[bus.imem_addr];

    // ---------------- scoreboard state ----------------
    logic [23:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic        exp_valid;
    logic        exp_halted;
    logic [15:0] exp_count;

    // instruction-flow model
    logic        m_valid;
    logic        m_halt;
    logic [7:0]  m_pc;
    logic [7:0]  m_next;
    logic [15:0] m_count;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        mon_en           = 1'b0;
        reset            = 1'b1;
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_offset = 9'd0;
        @(posedge clk); #1;
        chk("rst_addr",  32'(bus.imem_addr), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_pc",    32'(bus.instr_pc), 32'd0);
        chk("rst_ir",    32'(bus.instr), 32'd0);
        chk("rst_halt",  32'(bus.halted), 32'd0);
        chk("rst_count", 32'(bus.instr_count), 32'd0);
        reset   = 1'b0;
        m_valid = 1'b0;
        m_halt  = 1'b0;
        m_pc    = 8'd0;
        m_next  = 8'd0;
        m_count = 16'd0;
        exp_valid  = 1'b0;
        exp_halted = 1'b0;
        exp_count  = 16'd0;
        mon_en     = 1'b1;
        // start-up cycle: nothing presented regardless of inputs
        bus.stall = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
    endtask

    task automatic cycle(input bit st, input bit br, input logic [8:0] off);
        logic [7:0] tgt;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_offset = off;
        exp_valid  = m_valid;
        exp_halted = m_halt;
        exp_count  = m_count;
        if (m_valid && (br || !st)) exp_q.push_back({m_pc, imem[m_pc]});
        tgt = m_pc + 8'd1 + 8'(off);
        if (m_halt) begin
            // frozen until reset
        end else if (m_valid && imem[m_pc][15:12] == 4'hF && !st) begin
            m_valid = 1'b0;
            m_halt  = 1'b1;
        end else if (m_valid && br) begin
            m_next  = tgt;
            m_valid = 1'b0;
        end else if (!st) begin
            m_pc    = m_valid ? m_pc + 8'd1 : m_next;
            m_valid = 1'b1;
            m_count = m_count + 16'd1;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_until(input logic [7:0] pc);
        int n = 0;
        while (!(m_valid && m_pc == pc) && n < 400) begin
            cycle(1'b0, 1'b0, 9'd0);
            n++;
        end
        chk("reach_pc", 32'(m_valid && m_pc == pc), 32'd1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [23:0] e;
        if (mon_en) begin
            chk("valid",  32'(bus.instr_valid), 32'(exp_valid));
            chk("halted", 32'(bus.halted), 32'(exp_halted));
            chk("count",  32'(bus.instr_count), 32'(exp_count));
            if (bus.instr_valid && (!bus.stall || bus.branch_taken)) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_instr: got pc %0d with nothing expected", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc",  32'(bus.instr_pc), 32'(e[23:16]));
                    chk("instr",     32'(bus.instr), 32'(e[15:0]));
                    chk("opcode",    32'(bus.opcode), 32'(e[15:12]));
                    chk("immediate", 32'(bus.immediate), 32'(e[6:0]));
                    chk("nzimm",     32'(bus.nzimm), 32'(e[5:0]));
                    chk("offset",    32'(bus.offset), 32'(e[8:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_offset = 9'd0;
        for (int i = 0; i < 256; i++) imem[i] = 16'(i);

        // straight-line run, then a 3-cycle stall on pc 5
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 9'd0);
        run_until(8'd5);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 9'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 9'd0);
        // branch back by 4 from pc 10
        run_until(8'd10);
        cycle(1'b0, 1'b1, 9'h1FC);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 9'd0);

        // branch and stall together from pc 3
        do_reset();
        run_until(8'd3);
        cycle(1'b1, 1'b1, 9'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 9'd0);

        // wrap-around: 0 -> 250, 250 +10 -> 5, 5 -> 254 then through 255 -> 0
        do_reset();
        run_until(8'd0);
        cycle(1'b0, 1'b1, 9'd249);
        run_until(8'd250);
        cycle(1'b0, 1'b1, 9'd10);
        run_until(8'd5);
        cycle(1'b0, 1'b1, 9'd248);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 9'd0);

        // halt at pc 4, stall/branch afterwards are ignored
        imem[4] = 16'hF000;
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 9'd0);
        for (int i = 0; i < 5; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom));
        chk("halt_count", 32'(bus.instr_count), 32'd5);
        chk("halt_flag",  32'(bus.halted), 32'd1);

        // randomized program, stalls and branches, with a mid-run reset
        for (int i = 0; i < 256; i++) imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        do_reset();
        chk("post_halt_reset", 32'(bus.halted), 32'd0);
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, 9'($urandom));
        end
        mon_en = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
